mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency memory between instruction fetch (I) and load/store (D).

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-command signals around mem_port_arbiter.
// slave = arbiter view; master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_addr;
  logic                  if_cancel;
  logic                  if_done;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_stall;

  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [1:0]            dm_mask;
  logic                  dm_sext;
  logic                  dm_done;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [1:0]            mem_mask;
  logic                  mem_sext;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic [31:0]           conflict_cnt;

  modport slave (
    input  if_req, if_addr, if_cancel,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_mask, dm_sext,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_done, if_rdata, if_stall,
    output dm_done, dm_rdata, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mask, mem_sext,
    output conflict_cnt
  );

  modport master (
    output if_req, if_addr, if_cancel,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_mask, dm_sext,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_done, if_rdata, if_stall,
    input  dm_done, dm_rdata, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask, mem_sext,
    input  conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported variable-latency memory between instruction fetch and load/store.
// One transaction in flight; D has priority, I is forced after MAX_D_BURST consecutive D grants.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned BW = $clog2(MAX_D_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_D, OWN_I} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  kill_q, kill_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]            mem_mask_q, mem_mask_d;
  logic                  mem_sext_q, mem_sext_d;
  logic                  if_done_q, if_done_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  dm_done_q, dm_done_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic [31:0]           conflict_q, conflict_d;

  logic i_elig, burst_full, grant_i, grant_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_d     = burst_q;
    kill_d      = kill_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    mem_sext_d  = mem_sext_q;
    if_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_done_d   = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    conflict_d  = conflict_q;

    i_elig     = bus.if_req & ~bus.if_cancel;
    burst_full = (burst_q == BW'(MAX_D_BURST));
    grant_i    = 1'b0;
    grant_d    = 1'b0;

    if (owner_q == OWN_I && state_q != S_IDLE && bus.if_cancel) begin
      kill_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.if_req && bus.dm_req) begin
          conflict_d = conflict_q + 32'd1;
        end
        if (i_elig && (!bus.dm_req || burst_full)) begin
          grant_i = 1'b1;
        end else if (bus.dm_req) begin
          grant_d = 1'b1;
        end

        if (grant_i) begin
          state_d     = S_ISSUE;
          owner_d     = OWN_I;
          burst_d     = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_mask_d  = 2'b10;
          mem_sext_d  = 1'b0;
        end else if (grant_d) begin
          state_d     = S_ISSUE;
          owner_d     = OWN_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_mask_d  = bus.dm_mask;
          mem_sext_d  = bus.dm_sext;
          // Streak only grows while a fetch is actually waiting; saturates at the limit.
          if (!bus.if_req) begin
            burst_d = '0;
          end else if (!burst_full) begin
            burst_d = burst_q + BW'(1);
          end
        end
      end

      S_ISSUE: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = S_RESP;
          if (owner_q == OWN_I) begin
            if_rdata_d = bus.mem_rdata;
            // A cancel arriving together with the response must also suppress the pulse.
            if_done_d  = ~kill_q & ~bus.if_cancel;
          end else begin
            dm_rdata_d = bus.mem_rdata;
            dm_done_d  = 1'b1;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_D;
      burst_q     <= '0;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      mem_sext_q  <= 1'b0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_done_q   <= 1'b0;
      dm_rdata_q  <= '0;
      conflict_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      kill_q      <= kill_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      mem_sext_q  <= mem_sext_d;
      if_done_q   <= if_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_done_q   <= dm_done_d;
      dm_rdata_q  <= dm_rdata_d;
      conflict_q  <= conflict_d;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_mask     = mem_mask_q;
  assign bus.mem_sext     = mem_sext_q;
  assign bus.if_done      = if_done_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.dm_done      = dm_done_q;
  assign bus.dm_rdata     = dm_rdata_q;
  assign bus.conflict_cnt = conflict_q;
  assign bus.if_stall     = bus.if_req & ~if_done_q;
  assign bus.dm_stall     = bus.dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, a small memory responder,
// and a monitor that checks every done pulse and every accepted memory command.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.DATA_WIDTH(32), .MAX_D_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  mask;
    logic        sext;
    logic        is_d;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];

  int n_vec = 0;
  int n_err = 0;

  int          rdy_wait_cfg = 0;
  int          rsp_delay    = 1;
  int          rdy_cnt      = 0;
  int          rsp_cnt      = 0;
  bit          pending      = 1'b0;
  logic [31:0] acc_addr     = '0;
  logic [31:0] rsp_val      = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'hDEAD_0000);
  endfunction

  task automatic push_cmd(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [1:0] mask, input logic sext, input logic is_d);
    cmd_t c;
    c.addr = addr; c.we = we; c.wdata = wdata; c.mask = mask; c.sext = sext; c.is_d = is_d;
    exp_cmd.push_back(c);
  endtask

  task automatic check_cmd();
    cmd_t c;
    if (exp_cmd.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL cmd_unexpected: got command addr %h expected none", bus.mem_addr);
    end else begin
      c = exp_cmd.pop_front();
      check("cmd_addr", bus.mem_addr, c.addr);
      check("cmd_we", {31'd0, bus.mem_we}, {31'd0, c.we});
      if (c.is_d) begin
        check("cmd_mask", {30'd0, bus.mem_mask}, {30'd0, c.mask});
        check("cmd_sext", {31'd0, bus.mem_sext}, {31'd0, c.sext});
        if (c.we) check("cmd_wdata", bus.mem_wdata, c.wdata);
      end
    end
  endtask

  task automatic set_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] mask, input logic sext);
    bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
    bus.dm_mask = mask; bus.dm_sext = sext;
  endtask

  task automatic wait_for(input bit is_i, input int budget, input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(is_i ? bus.if_done : bus.dm_done) && cyc < budget);
    if (!(is_i ? bus.if_done : bus.dm_done)) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, cyc);
    end
  endtask

  // Memory responder: asserts mem_ready after rdy_wait_cfg stalled cycles,
  // answers rsp_delay cycles after acceptance regardless of arbiter state.
  initial begin
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (bus.mem_ready) begin
        pending = 1'b1;
        rsp_cnt = rsp_delay;
        rsp_val = mem_model(acc_addr);
      end
      if (pending) begin
        rsp_cnt--;
        if (rsp_cnt <= 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rsp_val;
          pending        = 1'b0;
        end
      end
      bus.mem_ready = 1'b0;
      if (!bus.mem_req) begin
        rdy_cnt = rdy_wait_cfg;
      end else if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (exp_cmd.size() > 0) check("bp_addr_stable", bus.mem_addr, exp_cmd[0].addr);
      end else begin
        bus.mem_ready = 1'b1;
        acc_addr      = bus.mem_addr;
        check_cmd();
      end
    end
  end

  // Monitor: every done pulse must match the next expected response on its side.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.if_done) begin
        if (exp_if.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL if_done_unexpected: got if_done=1 rdata %h expected no pulse", bus.if_rdata);
        end else check("if_rdata", bus.if_rdata, exp_if.pop_front());
      end
      if (bus.dm_done) begin
        if (exp_dm.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dm_done_unexpected: got dm_done=1 rdata %h expected no pulse", bus.dm_rdata);
        end else check("dm_rdata", bus.dm_rdata, exp_dm.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int k;

    // Reset held with both requests active
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.if_cancel = 1'b0;
    bus.dm_req = 1'b1;
    set_dm(1'b0, 32'h100, '0, 2'b10, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_if_done", {31'd0, bus.if_done}, 32'd0);
    check("rst_dm_done", {31'd0, bus.dm_done}, 32'd0);
    check("rst_conflict", bus.conflict_cnt, 32'd0);
    check("rst_if_stall", {31'd0, bus.if_stall}, 32'd1);
    rst = 1'b0; bus.if_req = 1'b0; bus.dm_req = 1'b0;
    @(negedge clk);

    // Lone fetch, minimum latency
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    push_cmd(32'h40, 1'b0, '0, 2'b00, 1'b0, 1'b0);
    exp_if.push_back(32'h0050_0093);
    wait_for(1'b1, 40, "fetch", cyc);
    check("fetch_latency", 32'(cyc + 1), 32'd4);
    check("fetch_stall_at_done", {31'd0, bus.if_stall}, 32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Simultaneous fetch and load: D first, then I
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.dm_req = 1'b1;
    set_dm(1'b0, 32'h100, '0, 2'b10, 1'b1);
    push_cmd(32'h100, 1'b0, '0, 2'b10, 1'b1, 1'b1);
    push_cmd(32'h44, 1'b0, '0, 2'b00, 1'b0, 1'b0);
    exp_dm.push_back(32'hDEAD_0100);
    exp_if.push_back(32'hDEAD_0044);
    wait_for(1'b0, 40, "conf_load", cyc);
    bus.dm_req = 1'b0;
    wait_for(1'b1, 40, "conf_fetch", cyc);
    bus.if_req = 1'b0;
    check("conflict_after_one", bus.conflict_cnt, 32'd1);
    @(negedge clk);

    // Store
    bus.dm_req = 1'b1;
    set_dm(1'b1, 32'h200, 32'h1234_5678, 2'b01, 1'b0);
    push_cmd(32'h200, 1'b1, 32'h1234_5678, 2'b01, 1'b0, 1'b1);
    exp_dm.push_back(32'hDEAD_0200);
    wait_for(1'b0, 40, "store", cyc);
    bus.dm_req = 1'b0;
    @(negedge clk);

    // Starvation limit: 4 D grants, then the held fetch, then remaining D
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    bus.dm_req = 1'b1;
    set_dm(1'b0, 32'h300, '0, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push_cmd(32'h300 + 32'(4 * i), 1'b0, '0, 2'b10, 1'b0, 1'b1);
      exp_dm.push_back(32'hDEAD_0300 + 32'(4 * i));
    end
    push_cmd(32'h80, 1'b0, '0, 2'b00, 1'b0, 1'b0);
    exp_if.push_back(32'hDEAD_0080);
    push_cmd(32'h310, 1'b0, '0, 2'b10, 1'b0, 1'b1);
    exp_dm.push_back(32'hDEAD_0310);
    k = 0; cyc = 0;
    while ((k < 5 || bus.if_req) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.dm_done) begin
        k++;
        if (k < 5) bus.dm_addr = 32'h300 + 32'(4 * k);
        else bus.dm_req = 1'b0;
      end
      if (bus.if_done) bus.if_req = 1'b0;
    end
    if (k < 5 || bus.if_req) begin
      n_vec++; n_err++;
      $display("FAIL starve_timeout: got %0d D dones, if_req=%0d expected 5 and 0", k, bus.if_req);
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
    end
    check("conflict_after_starve", bus.conflict_cnt, 32'd6);
    @(negedge clk);

    // Cancel in IDLE makes I ineligible
    bus.if_req = 1'b1; bus.if_cancel = 1'b1; bus.if_addr = 32'h99;
    @(negedge clk);
    check("cancel_idle_no_req", {31'd0, bus.mem_req}, 32'd0);
    bus.if_req = 1'b0; bus.if_cancel = 1'b0;
    @(negedge clk);

    // Cancel while fetch is in WAIT; queued load must follow
    rsp_delay = 4;
    bus.if_req = 1'b1; bus.if_addr = 32'h90;
    push_cmd(32'h90, 1'b0, '0, 2'b00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.if_cancel = 1'b1;
    bus.dm_req = 1'b1;
    set_dm(1'b0, 32'h400, '0, 2'b00, 1'b1);
    push_cmd(32'h400, 1'b0, '0, 2'b00, 1'b1, 1'b1);
    exp_dm.push_back(32'hDEAD_0400);
    @(negedge clk);
    bus.if_cancel = 1'b0; bus.if_req = 1'b0;
    wait_for(1'b0, 50, "after_cancel", cyc);
    bus.dm_req = 1'b0;
    rsp_delay = 1;
    @(negedge clk);

    // Back-pressure: mem_ready low for 5 cycles
    rdy_wait_cfg = 5;
    @(negedge clk);
    bus.dm_req = 1'b1;
    set_dm(1'b0, 32'h500, '0, 2'b10, 1'b0);
    push_cmd(32'h500, 1'b0, '0, 2'b10, 1'b0, 1'b1);
    exp_dm.push_back(32'hDEAD_0500);
    wait_for(1'b0, 50, "backpressure", cyc);
    check("bp_latency", 32'(cyc + 1), 32'd9);
    bus.dm_req = 1'b0;
    rdy_wait_cfg = 0;
    rsp_delay = 6;
    @(negedge clk);

    // Reset while in WAIT; the late response must be ignored
    bus.dm_req = 1'b1;
    set_dm(1'b0, 32'h600, '0, 2'b10, 1'b0);
    push_cmd(32'h600, 1'b0, '0, 2'b10, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1; bus.dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("midrst_dm_done", {31'd0, bus.dm_done}, 32'd0);
    check("midrst_conflict", bus.conflict_cnt, 32'd0);
    repeat (8) @(negedge clk);
    check("midrst_idle_req", {31'd0, bus.mem_req}, 32'd0);
    rsp_delay = 1;

    // Normal operation resumes after the stray response
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    push_cmd(32'h40, 1'b0, '0, 2'b00, 1'b0, 1'b0);
    exp_if.push_back(32'h0050_0093);
    wait_for(1'b1, 40, "post_rst_fetch", cyc);
    check("post_rst_latency", 32'(cyc + 1), 32'd4);
    bus.if_req = 1'b0;
    repeat (3) @(negedge clk);

    check("left_if", 32'(exp_if.size()), 32'd0);
    check("left_dm", 32'(exp_dm.size()), 32'd0);
    check("left_cmd", 32'(exp_cmd.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
